// File: rtl/seg7_pkg.sv
// Shared segment codes, anode level and width helper for the seven-segment scan driver.
package seg7_pkg;

  // Active-low cathode patterns {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0    = 7'h40;
  localparam logic [6:0] SEG_1    = 7'h79;
  localparam logic [6:0] SEG_2    = 7'h24;
  localparam logic [6:0] SEG_3    = 7'h30;
  localparam logic [6:0] SEG_4    = 7'h19;
  localparam logic [6:0] SEG_5    = 7'h12;
  localparam logic [6:0] SEG_6    = 7'h02;
  localparam logic [6:0] SEG_7    = 7'h78;
  localparam logic [6:0] SEG_8    = 7'h00;
  localparam logic [6:0] SEG_9    = 7'h10;
  localparam logic [6:0] SEG_DASH = 7'h3F;
  localparam logic [6:0] SEG_OFF  = 7'h7F;

  localparam logic AN_OFF = 1'b1;

  // Minimum 1 bit so single-entry counters still have a register
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned w;
    w = 1;
    while (w < 32 && (64'd1 << w) < 64'(n)) w++;
    return w;
  endfunction

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD nibble to active-low seven-segment decoder; non-BCD nibbles show a dash.
module bcd_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg_c
);

  always_comb begin
    seg_c = SEG_DASH;
    case (nibble)
      4'd0:    seg_c = SEG_0;
      4'd1:    seg_c = SEG_1;
      4'd2:    seg_c = SEG_2;
      4'd3:    seg_c = SEG_3;
      4'd4:    seg_c = SEG_4;
      4'd5:    seg_c = SEG_5;
      4'd6:    seg_c = SEG_6;
      4'd7:    seg_c = SEG_7;
      4'd8:    seg_c = SEG_8;
      4'd9:    seg_c = SEG_9;
      default: seg_c = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Multiplexed common-anode seven-segment driver with shadowed BCD/dp inputs and frame pulse.
// Optional leading-zero blanking when SEG7_LEADING_ZERO_BLANK_EN is defined.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int unsigned DIGITS       = 4,
  parameter int unsigned REFRESH_DIV  = 100000,
  parameter int unsigned BLANK_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*DIGITS-1:0]   bcd_in,
  input  logic                  load,
  input  logic [DIGITS-1:0]     dp_in,
  output logic [DIGITS-1:0]     an,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic                  frame_done
);

  localparam int unsigned PRESC_W = clog2(REFRESH_DIV);
  localparam int unsigned IDX_W   = clog2(DIGITS);
  localparam int unsigned BCD_W   = 4 * DIGITS;

  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(REFRESH_DIV - 1);
  localparam logic [PRESC_W-1:0] BLANK_END  = PRESC_W'(BLANK_CYCLES);
  localparam logic [IDX_W-1:0]   IDX_LAST   = IDX_W'(DIGITS - 1);

  logic [PRESC_W-1:0] presc_q, presc_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [BCD_W-1:0]   shadow_bcd_q, shadow_bcd_d;
  logic [DIGITS-1:0]  shadow_dp_q, shadow_dp_d;
  logic [DIGITS-1:0]  an_q, an_d;
  logic [6:0]         seg_q, seg_d;
  logic               dp_q, dp_d;
  logic               frame_done_q, frame_done_d;

  logic [3:0]         nibble_c;
  logic [6:0]         dec_seg_c;
  logic               lz_blank_c;
  logic               slot_end_c;
  logic               drive_c;

  assign nibble_c = shadow_bcd_q[{idx_q, 2'b00} +: 4];

  bcd_to_seg7 u_dec (
    .nibble (nibble_c),
    .seg_c  (dec_seg_c)
  );

  // A digit above 0 is blank when it and every more significant nibble are zero
`ifdef SEG7_LEADING_ZERO_BLANK_EN
  assign lz_blank_c = (idx_q != '0) && ((shadow_bcd_q >> {idx_q, 2'b00}) == '0);
`else
  assign lz_blank_c = 1'b0;
`endif

  // Outputs are computed from the current counters/shadow and appear one cycle later
  always_comb begin
    slot_end_c   = (presc_q == PRESC_LAST);
    drive_c      = (presc_q >= BLANK_END);
    presc_d      = slot_end_c ? '0 : presc_q + PRESC_W'(1);
    idx_d        = idx_q;
    shadow_bcd_d = shadow_bcd_q;
    shadow_dp_d  = shadow_dp_q;
    an_d         = {DIGITS{AN_OFF}};
    seg_d        = SEG_OFF;
    dp_d         = 1'b1;
    frame_done_d = slot_end_c && (idx_q == IDX_LAST);

    if (slot_end_c) begin
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
    end
    if (load) begin
      shadow_bcd_d = bcd_in;
      shadow_dp_d  = dp_in;
    end
    if (drive_c) begin
      an_d  = ~(DIGITS'(1) << idx_q);
      seg_d = lz_blank_c ? SEG_OFF : dec_seg_c;
      dp_d  = ~shadow_dp_q[idx_q];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      presc_q      <= '0;
      idx_q        <= '0;
      shadow_bcd_q <= '0;
      shadow_dp_q  <= '0;
      an_q         <= {DIGITS{AN_OFF}};
      seg_q        <= SEG_OFF;
      dp_q         <= 1'b1;
      frame_done_q <= 1'b0;
    end else begin
      presc_q      <= presc_d;
      idx_q        <= idx_d;
      shadow_bcd_q <= shadow_bcd_d;
      shadow_dp_q  <= shadow_dp_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign an         = an_q;
  assign seg        = seg_q;
  assign dp         = dp_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Randomized self-checking bench for seg7_scan_driver against a time-indexed reference model.
module tb_seg7_scan_driver;

  localparam int unsigned D = 4;
  localparam int unsigned R = 8;
  localparam int unsigned B = 1;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] bcd_in;
  logic        load;
  logic [3:0]  dp_in;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        frame_done;

  int errors = 0;
  int checks = 0;

  // Model state: cycles elapsed since reset release, and shadow contents
  int          e;
  logic [15:0] m_bcd;
  logic [3:0]  m_dp;
  logic [6:0]  seg_tab [16];

  always #5 clk = ~clk;

  seg7_scan_driver #(
    .DIGITS       (D),
    .REFRESH_DIV  (R),
    .BLANK_CYCLES (B)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .bcd_in     (bcd_in),
    .load       (load),
    .dp_in      (dp_in),
    .an         (an),
    .seg        (seg),
    .dp         (dp),
    .frame_done (frame_done)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at t=%0t cycle=%0d: got %0h expected %0h", tag, $time, e, got, exp);
    end
  endtask

  // One clock: drive inputs, predict the post-edge outputs, then compare
  task automatic step(input logic ld, input logic [15:0] b, input logic [3:0] p);
    int          presc;
    int          idx;
    logic [3:0]  nib;
    logic [3:0]  exp_an;
    logic [6:0]  exp_seg;
    logic        exp_dp;
    logic        exp_fd;
    load   = ld;
    bcd_in = b;
    dp_in  = p;
    presc  = e % R;
    idx    = (e / R) % D;
    exp_fd = ((e % (R * D)) == (R * D - 1));
    exp_an = (presc < B) ? 4'hF : ~(4'b0001 << idx);
    nib    = m_bcd[4*idx +: 4];
    exp_seg = seg_tab[nib];
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    if (idx != 0 && (m_bcd >> (4 * idx)) == 16'h0000) exp_seg = 7'h7F;
`endif
    exp_dp = ~m_dp[idx];
    @(posedge clk);
    #1;
    if (ld) begin
      m_bcd = b;
      m_dp  = p;
    end
    e++;
    check("an", 32'(an), 32'(exp_an));
    check("frame_done", 32'(frame_done), 32'(exp_fd));
    if (exp_an != 4'hF) begin
      check("seg", 32'(seg), 32'(exp_seg));
      check("dp", 32'(dp), 32'(exp_dp));
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 16'($urandom), 4'($urandom));
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_an"}, 32'(an), 32'hF);
    check({tag, "_seg"}, 32'(seg), 32'h7F);
    check({tag, "_dp"}, 32'(dp), 32'h1);
    check({tag, "_fd"}, 32'(frame_done), 32'h0);
  endtask

  // Asynchronous reset mid-cycle, held for a few edges, released at a falling edge
  task automatic do_reset();
    @(negedge clk);
    #2;
    rst  = 1'b0;
    load = 1'b0;
    #1;
    check_reset_vals("rst_async");
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check_reset_vals("rst_hold");
    end
    @(negedge clk);
    rst   = 1'b1;
    e     = 0;
    m_bcd = 16'h0000;
    m_dp  = 4'h0;
  endtask

  initial begin
    seg_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                7'h00, 7'h10, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F};
    rst    = 1'b1;
    load   = 1'b0;
    bcd_in = 16'h0000;
    dp_in  = 4'h0;
    e      = 0;
    m_bcd  = 16'h0000;
    m_dp   = 4'h0;
    #1 rst = 1'b0;
    #1;
    check_reset_vals("rst_init");
    do_reset();

    // Scan order and decimal point
    step(1'b1, 16'h1234, 4'b0100);
    idle(40);

    // Non-BCD nibble shows a dash
    step(1'b1, 16'h00A9, 4'b0000);
    idle(34);

    // Leading zeros (blank or '0' depending on build)
    step(1'b1, 16'h0007, 4'b1000);
    idle(34);
    step(1'b1, 16'h0000, 4'b0001);
    idle(34);

    // Reset in the middle of a frame clears the shadow
    do_reset();
    step(1'b1, 16'h5678, 4'hF);
    idle(12);
    do_reset();
    idle(34);

    // Random loads, often with few significant digits
    for (int i = 0; i < 400; i++) begin
      logic [15:0] rb;
      rb = 16'($urandom) >> $urandom_range(0, 16);
      step(($urandom_range(0, 9) == 0), rb, 4'($urandom));
      if (i == 200) begin
        do_reset();
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
